game_sequencer: RTL and testbench

Downstream game-flow controller for the Zoordian mastermind design. Consumes the round-start, pattern-ready and graded-guess events produced by the coin, pattern-load and grader stages, then tracks guesses within a game. Declares win or loss and generates the credit-consume, guess-enable and reveal controls that feed back to the coin stage, the LEDs and the VGA stage.

---
 rtl/game_sequencer_if.sv | 39 +++
 rtl/game_sequencer.sv | 114 +++++++++++
 tb/tb_game_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Handshake bundle between the upstream coin/pattern/grader stages and game_sequencer.
// The score signal exists only when GAME_SEQUENCER_SCORE_EN is defined.
interface game_sequencer_if;
   logic [3:0] num_games;
   logic       start_game;
   logic       pattern_ready;
   logic       guess_ready;
   logic [3:0] znarly;
   logic [3:0] zood;
   logic       consume_credit;
   logic       no_credit;
   logic       guess_enable;
   logic       reveal_pattern;
   logic       game_won;
   logic       game_lost;
   logic [3:0] guesses_used;
   logic       grade_error;
`ifdef GAME_SEQUENCER_SCORE_EN
   logic [7:0] score;
`endif

   modport master (
`ifdef GAME_SEQUENCER_SCORE_EN
      input  score,
`endif
      output num_games, start_game, pattern_ready, guess_ready, znarly, zood,
      input  consume_credit, no_credit, guess_enable, reveal_pattern,
      input  game_won, game_lost, guesses_used, grade_error
   );

   modport slave (
`ifdef GAME_SEQUENCER_SCORE_EN
      output score,
`endif
      input  num_games, start_game, pattern_ready, guess_ready, znarly, zood,
      output consume_credit, no_credit, guess_enable, reveal_pattern,
      output game_won, game_lost, guesses_used, grade_error
   );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: credits, pattern wait, guess counting, win/loss and reveal.
// Optional accumulated score enabled by defining GAME_SEQUENCER_SCORE_EN.
module game_sequencer #(
   parameter int MAX_ROUNDS = 8,
   parameter int WIN_ZNARLY = 4
) (
   input logic             CLOCK_50,
   input logic             reset,
   game_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WAIT_PATTERN, PLAY, WON, LOST} state_t;

   state_t     state_reg, state_next;
   logic [3:0] used_reg, used_next;
   logic [4:0] used_inc;
   logic [4:0] grade_sum;
   logic       consume_next, no_credit_next, grade_error_next;

   logic       consume_reg, no_credit_reg, grade_error_reg;
   logic       guess_enable_reg, reveal_reg, won_reg, lost_reg;

   always_comb begin
      state_next       = state_reg;
      used_next        = used_reg;
      consume_next     = 1'b0;
      no_credit_next   = 1'b0;
      grade_error_next = 1'b0;
      used_inc         = {1'b0, used_reg} + 5'd1;
      grade_sum        = {1'b0, bus.znarly} + {1'b0, bus.zood};
      case (state_reg)
         IDLE, WON, LOST: begin
            if (bus.start_game) begin
               if (bus.num_games != 4'd0) begin
                  state_next   = WAIT_PATTERN;
                  consume_next = 1'b1;
                  used_next    = 4'd0;
               end else begin
                  no_credit_next = 1'b1;
               end
            end
         end
         WAIT_PATTERN: begin
            if (bus.pattern_ready) state_next = PLAY;
         end
         PLAY: begin
            // start_game is deliberately not looked at: a game cannot be abandoned
            if (bus.guess_ready) begin
               used_next        = used_inc[3:0];
               grade_error_next = (grade_sum > 5'd4);
               if (bus.znarly == 4'(WIN_ZNARLY))
                  state_next = WON;
               else if (used_inc == 5'(MAX_ROUNDS))
                  state_next = LOST;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_reg        <= IDLE;
         used_reg         <= 4'd0;
         consume_reg      <= 1'b0;
         no_credit_reg    <= 1'b0;
         grade_error_reg  <= 1'b0;
         guess_enable_reg <= 1'b0;
         reveal_reg       <= 1'b0;
         won_reg          <= 1'b0;
         lost_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         used_reg         <= used_next;
         consume_reg      <= consume_next;
         no_credit_reg    <= no_credit_next;
         grade_error_reg  <= grade_error_next;
         guess_enable_reg <= (state_next == PLAY);
         reveal_reg       <= (state_next == WON) || (state_next == LOST);
         won_reg          <= (state_next == WON);
         lost_reg         <= (state_next == LOST);
      end
   end

`ifdef GAME_SEQUENCER_SCORE_EN
   logic [7:0] score_reg, score_next;
   logic [8:0] score_sum;
   logic       win_evt;

   // Fewer guesses earn more points; guesses_used is always below MAX_ROUNDS here
   always_comb begin
      win_evt    = (state_reg == PLAY) && bus.guess_ready && (bus.znarly == 4'(WIN_ZNARLY));
      score_sum  = {1'b0, score_reg} + 9'(MAX_ROUNDS) - {5'd0, used_reg};
      score_next = score_reg;
      if (win_evt)
         score_next = (score_sum > 9'd255) ? 8'd255 : score_sum[7:0];
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) score_reg <= 8'd0;
      else       score_reg <= score_next;
   end

   assign bus.score = score_reg;
`endif

   assign bus.consume_credit = consume_reg;
   assign bus.no_credit      = no_credit_reg;
   assign bus.grade_error    = grade_error_reg;
   assign bus.guess_enable   = guess_enable_reg;
   assign bus.reveal_pattern = reveal_reg;
   assign bus.game_won       = won_reg;
   assign bus.game_lost      = lost_reg;
   assign bus.guesses_used   = used_reg;
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural model pushes the expected
// output snapshot per cycle, which is popped and compared one edge later.
module tb_game_sequencer;
   localparam int MAXR = 8;
   localparam int WINZ = 4;

   typedef struct packed {
      logic       cc, nc, ge, rv, won, lost;
      logic [3:0] used;
      logic       gerr;
      logic [7:0] score;
   } snap_t;

   typedef struct packed {
      logic       r, st, pr, gr;
      logic [3:0] num, zn, zo;
   } stim_t;

   logic CLOCK_50 = 1'b0;
   logic reset;
   game_sequencer_if bus();

   game_sequencer #(.MAX_ROUNDS(MAXR), .WIN_ZNARLY(WINZ)) dut (
      .CLOCK_50(CLOCK_50),
      .reset(reset),
      .bus(bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int    checks = 0;
   int    errors = 0;
   snap_t sb[$];

   // reference model state: 0 idle, 1 wait, 2 play, 3 won, 4 lost
   int m_state = 0;
   int m_used  = 0;
   int m_score = 0;

   function automatic stim_t mk(input logic r, st, pr, gr, input logic [3:0] n, z, o);
      stim_t s;
      s = '{r: r, st: st, pr: pr, gr: gr, num: n, zn: z, zo: o};
      return s;
   endfunction

   task automatic drive(input stim_t s);
      reset             = s.r;
      bus.start_game    = s.st;
      bus.pattern_ready = s.pr;
      bus.guess_ready   = s.gr;
      bus.num_games     = s.num;
      bus.znarly        = s.zn;
      bus.zood          = s.zo;
   endtask

   task automatic predict();
      snap_t e;
      e = '0;
      if (reset) begin
         m_state = 0; m_used = 0; m_score = 0;
      end else if (m_state == 0 || m_state == 3 || m_state == 4) begin
         if (bus.start_game && bus.num_games != 0) begin
            m_state = 1; m_used = 0; e.cc = 1'b1;
         end else if (bus.start_game) begin
            e.nc = 1'b1;
         end
      end else if (m_state == 1) begin
         if (bus.pattern_ready) m_state = 2;
      end else if (m_state == 2 && bus.guess_ready) begin
         e.gerr = (int'(bus.znarly) + int'(bus.zood)) > 4;
         if (int'(bus.znarly) == WINZ) begin
            m_score = m_score + MAXR - m_used;
            if (m_score > 255) m_score = 255;
            m_state = 3;
         end else if (m_used + 1 == MAXR) begin
            m_state = 4;
         end
         m_used = m_used + 1;
      end
      e.ge   = (m_state == 2);
      e.rv   = (m_state == 3) || (m_state == 4);
      e.won  = (m_state == 3);
      e.lost = (m_state == 4);
      e.used = 4'(m_used);
`ifdef GAME_SEQUENCER_SCORE_EN
      e.score = 8'(m_score);
`endif
      sb.push_back(e);
   endtask

   function automatic snap_t observe();
      snap_t o;
      o = '0;
      o.cc = bus.consume_credit; o.nc = bus.no_credit; o.ge = bus.guess_enable;
      o.rv = bus.reveal_pattern; o.won = bus.game_won; o.lost = bus.game_lost;
      o.used = bus.guesses_used; o.gerr = bus.grade_error;
`ifdef GAME_SEQUENCER_SCORE_EN
      o.score = bus.score;
`endif
      return o;
   endfunction

   task automatic test_reset();
      stim_t seq[$];
      snap_t exp, got;
      seq = '{mk(1,0,0,0,0,0,0), mk(1,1,1,1,3,4,0)};
      foreach (seq[i]) begin
         drive(seq[i]); predict();
         @(posedge CLOCK_50); #1;
         exp = sb.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL reset[%0d] got=%h want=%h", i, got, exp);
         end else $display("reset[%0d] outputs=%h", i, got);
      end
      checks++;
      if (bus.guess_enable !== 1'b0 || bus.guesses_used !== 4'd0 || bus.consume_credit !== 1'b0) begin
         errors++; $display("FAIL reset_values got ge=%b used=%0d cc=%b want 0 0 0",
                            bus.guess_enable, bus.guesses_used, bus.consume_credit);
      end
   endtask

   task automatic test_no_credit();
      stim_t seq[$];
      snap_t exp, got;
      seq = '{mk(0,1,0,0,0,0,0), mk(0,0,0,0,0,0,0), mk(0,0,1,1,3,4,0), mk(0,0,0,0,3,0,0)};
      foreach (seq[i]) begin
         drive(seq[i]); predict();
         @(posedge CLOCK_50); #1;
         exp = sb.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL no_credit[%0d] got=%h want=%h", i, got, exp);
         end else $display("no_credit[%0d] outputs=%h", i, got);
      end
      checks++;
      if (bus.guesses_used !== 4'd0 || bus.reveal_pattern !== 1'b0) begin
         errors++; $display("FAIL idle_ignores_guess got used=%0d rv=%b want 0 0",
                            bus.guesses_used, bus.reveal_pattern);
      end
   endtask

   task automatic test_start();
      stim_t seq[$];
      snap_t exp, got;
      seq = '{mk(0,1,0,0,3,0,0), mk(0,1,0,0,3,0,0), mk(0,0,0,1,3,4,0),
              mk(0,0,1,0,3,0,0), mk(0,0,1,0,3,0,0)};
      foreach (seq[i]) begin
         drive(seq[i]); predict();
         @(posedge CLOCK_50); #1;
         exp = sb.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL start[%0d] got=%h want=%h", i, got, exp);
         end else $display("start[%0d] outputs=%h", i, got);
      end
      checks++;
      if (bus.guess_enable !== 1'b1 || bus.guesses_used !== 4'd0) begin
         errors++; $display("FAIL start_play got ge=%b used=%0d want 1 0",
                            bus.guess_enable, bus.guesses_used);
      end
   endtask

   task automatic test_win();
      stim_t seq[$];
      snap_t exp, got;
      // last guess also carries start_game: it must be dropped
      seq = '{mk(0,0,0,1,3,1,0), mk(0,0,0,0,3,0,0), mk(0,0,0,1,3,2,1),
              mk(0,1,0,1,3,4,0), mk(0,0,0,1,3,4,0)};
      foreach (seq[i]) begin
         drive(seq[i]); predict();
         @(posedge CLOCK_50); #1;
         exp = sb.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL win[%0d] got=%h want=%h", i, got, exp);
         end else $display("win[%0d] outputs=%h", i, got);
      end
      checks++;
      if (bus.game_won !== 1'b1 || bus.reveal_pattern !== 1'b1 || bus.guesses_used !== 4'd3) begin
         errors++; $display("FAIL win_final got won=%b rv=%b used=%0d want 1 1 3",
                            bus.game_won, bus.reveal_pattern, bus.guesses_used);
      end
`ifdef GAME_SEQUENCER_SCORE_EN
      checks++;
      if (bus.score !== 8'd6) begin
         errors++; $display("FAIL win_score got=%0d want=6", bus.score);
      end
`endif
   endtask

   task automatic test_back_to_back();
      stim_t seq[$];
      snap_t exp, got;
      seq = '{mk(0,1,0,0,3,0,0), mk(0,0,1,0,3,0,0)};
      for (int g = 0; g < 9; g++) seq.push_back(mk(0, (g == 2), 0, 1, 3, 2, 1));
      seq.push_back(mk(0,0,0,0,3,0,0));
      foreach (seq[i]) begin
         drive(seq[i]); predict();
         @(posedge CLOCK_50); #1;
         exp = sb.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL loss[%0d] got=%h want=%h", i, got, exp);
         end else $display("loss[%0d] outputs=%h", i, got);
      end
      checks++;
      if (bus.game_lost !== 1'b1 || bus.guesses_used !== 4'd8 || bus.guess_enable !== 1'b0) begin
         errors++; $display("FAIL loss_final got lost=%b used=%0d ge=%b want 1 8 0",
                            bus.game_lost, bus.guesses_used, bus.guess_enable);
      end
   endtask

   task automatic test_first_guess_win();
      stim_t seq[$];
      snap_t exp, got;
      seq = '{mk(0,1,0,0,2,0,0), mk(0,0,1,0,2,0,0), mk(0,0,0,1,2,4,0), mk(0,0,0,0,2,0,0)};
      foreach (seq[i]) begin
         drive(seq[i]); predict();
         @(posedge CLOCK_50); #1;
         exp = sb.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL first_win[%0d] got=%h want=%h", i, got, exp);
         end else $display("first_win[%0d] outputs=%h", i, got);
      end
      checks++;
      if (bus.game_won !== 1'b1 || bus.guesses_used !== 4'd1) begin
         errors++; $display("FAIL first_win_final got won=%b used=%0d want 1 1",
                            bus.game_won, bus.guesses_used);
      end
`ifdef GAME_SEQUENCER_SCORE_EN
      checks++;
      if (bus.score !== 8'd14) begin
         errors++; $display("FAIL first_win_score got=%0d want=14", bus.score);
      end
`endif
   endtask

   task automatic test_grade_error();
      stim_t seq[$];
      snap_t exp, got;
      seq = '{mk(0,1,0,0,1,0,0), mk(0,0,1,0,1,0,0), mk(0,0,0,1,1,3,2),
              mk(0,0,0,1,1,1,3), mk(0,0,0,1,1,0,0), mk(0,0,0,0,1,0,0),
              mk(0,0,0,1,1,0,0), mk(0,0,0,1,1,2,2)};
      foreach (seq[i]) begin
         drive(seq[i]); predict();
         @(posedge CLOCK_50); #1;
         exp = sb.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL grade[%0d] got=%h want=%h", i, got, exp);
         end else $display("grade[%0d] outputs=%h", i, got);
         if (i == 2) begin
            checks++;
            if (bus.grade_error !== 1'b1 || bus.guesses_used !== 4'd1 || bus.guess_enable !== 1'b1) begin
               errors++; $display("FAIL grade_pulse got gerr=%b used=%0d ge=%b want 1 1 1",
                                  bus.grade_error, bus.guesses_used, bus.guess_enable);
            end
         end
      end
      checks++;
      if (bus.guesses_used !== 4'd5 || bus.grade_error !== 1'b0) begin
         errors++; $display("FAIL grade_final got used=%0d gerr=%b want 5 0",
                            bus.guesses_used, bus.grade_error);
      end
   endtask

   task automatic test_reset_mid_game();
      stim_t seq[$];
      snap_t exp, got;
      seq = '{mk(1,1,0,1,3,3,2), mk(0,0,0,0,3,0,0)};
      foreach (seq[i]) begin
         drive(seq[i]); predict();
         @(posedge CLOCK_50); #1;
         exp = sb.pop_front(); got = observe();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL mid_reset[%0d] got=%h want=%h", i, got, exp);
         end else $display("mid_reset[%0d] outputs=%h", i, got);
      end
      checks++;
      if (observe() !== snap_t'(0)) begin
         errors++; $display("FAIL mid_reset_clear got=%h want=0", observe());
      end
   endtask

   initial begin
      drive(mk(1,0,0,0,0,0,0));
      @(posedge CLOCK_50); #1;
      test_reset();
      test_no_credit();
      test_start();
      test_win();
      test_back_to_back();
      test_first_guess_win();
      test_grade_error();
      test_reset_mid_game();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
